// File: rtl/sparc_mem_pkg.sv
// Shared opcode, error-code and FSM definitions for the SPARC memory path.
package sparc_mem_pkg;

   // Memory opcodes as presented by the datapath and forwarded to the RAM.
   localparam logic [5:0] OP_LDUB = 6'h01;
   localparam logic [5:0] OP_LDUH = 6'h02;
   localparam logic [5:0] OP_LDW  = 6'h08;
   localparam logic [5:0] OP_LDSB = 6'h09;
   localparam logic [5:0] OP_LDSH = 6'h0A;
   localparam logic [5:0] OP_STB  = 6'h05;
   localparam logic [5:0] OP_STH  = 6'h06;
   localparam logic [5:0] OP_STW  = 6'h04;

   // Completion status reported alongside done.
   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

   // Controller states, in the order an access normally walks them.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_SETUP,
      ST_ACTIVE,
      ST_RELEASE,
      ST_FINISH
   } state_t;

   // True for every opcode that returns data into rdata.
   function automatic logic is_load(input logic [5:0] op);
      logic res;
      res = (op == OP_LDUB) || (op == OP_LDUH) || (op == OP_LDW) ||
            (op == OP_LDSB) || (op == OP_LDSH);
      return res;
   endfunction

   // Bytes moved by an opcode; 0 marks an opcode the RAM does not understand.
   function automatic logic [2:0] access_size(input logic [5:0] op);
      logic [2:0] res;
      case (op)
         OP_LDUB, OP_LDSB, OP_STB: res = 3'd1;
         OP_LDUH, OP_LDSH, OP_STH: res = 3'd2;
         OP_LDW,  OP_STW:          res = 3'd4;
         default:                  res = 3'd0;
      endcase
      return res;
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      return access_size(op) != 3'd0;
   endfunction

   // Halfwords need an even address, words a multiple of four.
   function automatic logic is_misaligned(input logic [5:0] op, input logic [7:0] addr);
      logic res;
      case (access_size(op))
         3'd2:    res = addr[0];
         3'd4:    res = |addr[1:0];
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mfc_sync.sv
// Two-flop synchronizer bringing the RAM's asynchronous MFC into the clk domain.
module mfc_sync (
   input  logic clk,
   input  logic reset,
   input  logic mfc_raw,
   output logic mfc_synced
);

   logic meta;

   // Shift the raw level through two flops; reset clears both stages.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta       <= 1'b0;
         mfc_synced <= 1'b0;
      end else begin
         meta       <= mfc_raw;
         mfc_synced <= meta;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller running the MFA/MFC handshake to the asynchronous ram_256b.
//
// Datapath handshake: req is sampled only while busy is low (IDLE). The
// accepting edge raises busy; busy stays high until the edge that raises the
// single-cycle done pulse (with err/err_code valid in that same cycle). A new
// req may be presented during the done cycle and is accepted on the next edge.
module mem_access_ctrl
   import sparc_mem_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64,
   parameter int SETUP_CYC   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [5:0]  op,
   input  logic [7:0]  addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        mfa,
   output logic [5:0]  ram_op,
   output logic [7:0]  ram_addr,
   output logic [31:0] ram_din,
   input  logic [31:0] ram_dout,
   input  logic        mfc
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int SW = $clog2(SETUP_CYC + 1);

   state_t        state;
   state_t        state_nxt;
   logic [1:0]    err_q;
   logic [1:0]    err_nxt;
   logic [5:0]    op_q;
   logic [7:0]    addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rbuf;
   logic [TW-1:0] tcnt;
   logic [SW-1:0] scnt;
   logic          mfc_s;
   logic          setup_done;
   logic          timed_out;

   mfc_sync u_mfc_sync (
      .clk        (clk),
      .reset      (reset),
      .mfc_raw    (mfc),
      .mfc_synced (mfc_s)
   );

   // The wait that reaches TIMEOUT_CYC cycles gives up on this edge.
   assign timed_out  = (tcnt == TW'(TIMEOUT_CYC - 1));
   assign setup_done = (scnt == SW'(SETUP_CYC - 1));

   // Next-state and pending error code for the access sequence.
   always_comb begin
      state_nxt = state;
      err_nxt   = err_q;
      case (state)
         ST_IDLE: begin
            if (req) begin
               state_nxt = ST_CHECK;
               err_nxt   = ERR_NONE;
            end
         end
         ST_CHECK: begin
            if (!is_legal(op_q)) begin
               state_nxt = ST_FINISH;
               err_nxt   = ERR_ILLEGAL;
            end else if (is_misaligned(op_q, addr_q)) begin
               state_nxt = ST_FINISH;
               err_nxt   = ERR_MISALIGN;
            end else begin
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (setup_done) state_nxt = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (mfc_s) begin
               state_nxt = ST_RELEASE;
            end else if (timed_out) begin
               state_nxt = ST_FINISH;
               err_nxt   = ERR_TIMEOUT;
            end
         end
         ST_RELEASE: begin
            if (!mfc_s) begin
               state_nxt = ST_FINISH;
            end else if (timed_out) begin
               state_nxt = ST_FINISH;
               err_nxt   = ERR_TIMEOUT;
            end
         end
         ST_FINISH: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register and latched error code.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         err_q <= ERR_NONE;
      end else begin
         state <= state_nxt;
         err_q <= err_nxt;
      end
   end

   // Capture the request so the datapath may change its lines after acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q    <= 6'h00;
         addr_q  <= 8'h00;
         wdata_q <= 32'h0;
      end else if (state == ST_IDLE && req) begin
         op_q    <= op;
         addr_q  <= addr;
         wdata_q <= wdata;
      end
   end

   // Setup-hold counter runs only in SETUP; timeout counter restarts per wait phase and saturates.
   always_ff @(posedge clk) begin
      if (reset) begin
         scnt <= '0;
         tcnt <= '0;
      end else begin
         if (state == ST_SETUP) scnt <= scnt + SW'(1);
         else                   scnt <= '0;

         if ((state_nxt == ST_ACTIVE  && state != ST_ACTIVE) ||
             (state_nxt == ST_RELEASE && state != ST_RELEASE)) begin
            tcnt <= '0;
         end else if ((state == ST_ACTIVE || state == ST_RELEASE) &&
                      tcnt != TW'(TIMEOUT_CYC)) begin
            tcnt <= tcnt + TW'(1);
         end
      end
   end

   // RAM lines load once when SETUP begins and then stay put through RELEASE.
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_op   <= 6'h00;
         ram_addr <= 8'h00;
         ram_din  <= 32'h0;
      end else if (state == ST_CHECK && state_nxt == ST_SETUP) begin
         ram_op   <= op_q;
         ram_addr <= addr_q;
         ram_din  <= wdata_q;
      end
   end

   // Load data is buffered when MFC is seen and only published on a clean finish.
   always_ff @(posedge clk) begin
      if (reset) begin
         rbuf  <= 32'h0;
         rdata <= 32'h0;
      end else begin
         if (state == ST_ACTIVE && mfc_s && is_load(op_q)) rbuf <= ram_dout;
         if (state == ST_FINISH && err_q == ERR_NONE && is_load(op_q)) rdata <= rbuf;
      end
   end

   // Registered handshake and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         mfa      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         mfa      <= (state_nxt == ST_ACTIVE);
         busy     <= (state_nxt != ST_IDLE);
         done     <= (state == ST_FINISH);
         err      <= (state == ST_FINISH) && (err_q != ERR_NONE);
         err_code <= (state == ST_FINISH) ? err_q : ERR_NONE;
      end
   end

endmodule
